// File: rtl/mig_app_arbiter_pkg.sv
// Shared definitions for the two-client MIG app-interface arbiter.
// Holds MIG command encodings, the arbiter FSM state type and a
// ceil-log2 helper used to size the read-ID FIFO pointers.
package mig_app_arbiter_pkg;

  // MIG native app_cmd encodings
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Smallest r with 2**r >= v (v >= 1).
  function automatic int log2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mig_app_arbiter_id_fifo.sv
// Purpose : 1-bit-wide FIFO of client IDs for reads issued to MIG, in command order.
// Latency : push visible at head_o next cycle; pop advances head next cycle.
// Backpr. : full_o/empty_o flags; push when full (without pop) and pop when empty are ignored.
// Ports   : clk, reset_n (async active-low); push_i/push_id_i write side;
//           pop_i read side; head_o = ID at the read pointer; full_o/empty_o status.
module mig_app_arbiter_id_fifo
  import mig_app_arbiter_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = log2c(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a push at full is still safe then.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mig_app_arbiter.sv
// Purpose : round-robin share of one MIG native app port between clients c0 and c1,
//           with in-order routing of read returns back to the issuing client.
// Latency : grant -> app_en/app_wdf_wren next cycle; last MIG handshake -> cN_ack next
//           cycle; app_rd_data_valid -> cN_rd_valid/rd_data next cycle.
// Backpr. : app_en / app_wdf_wren held until app_rdy / app_wdf_rdy; clients hold
//           cN_req until cN_ack; reads are not granted while the ID FIFO is full.
// Ports   : clk, reset_n (async active-low); cN_req/rd/addr/wdata/ack/rd_valid client side;
//           rd_data shared return data; error sticky unexpected-return flag;
//           app_* MIG native interface (cmd, write data, read return).
module mig_app_arbiter
  import mig_app_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 27,
  parameter int APP_DATA_WIDTH = 128,
  parameter int TAG_DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  // client 0
  input  logic                      c0_req,
  input  logic                      c0_rd,
  input  logic [ADDR_WIDTH-1:0]     c0_addr,
  input  logic [APP_DATA_WIDTH-1:0] c0_wdata,
  output logic                      c0_ack,
  output logic                      c0_rd_valid,
  // client 1
  input  logic                      c1_req,
  input  logic                      c1_rd,
  input  logic [ADDR_WIDTH-1:0]     c1_addr,
  input  logic [APP_DATA_WIDTH-1:0] c1_wdata,
  output logic                      c1_ack,
  output logic                      c1_rd_valid,
  // shared read return and status
  output logic [APP_DATA_WIDTH-1:0] rd_data,
  output logic                      error,
  // MIG native app interface
  input  logic                      app_rdy,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  input  logic                      app_wdf_rdy,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  input  logic                      app_rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data
);

  arb_state_e                state_q, state_d;
  logic                      last_gnt_q, last_gnt_d;
  logic                      gnt_id_q, gnt_id_d;
  logic                      app_en_q, app_en_d;
  logic                      wren_q, wren_d;
  logic [2:0]                cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [APP_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      cmd_done_q, cmd_done_d;
  logic                      data_done_q, data_done_d;
  logic [1:0]                ack_q, ack_d;
  logic [1:0]                rd_valid_q, rd_valid_d;
  logic [APP_DATA_WIDTH-1:0] rd_data_q;
  logic                      error_q, error_d;

  logic                      elig0, elig1;
  logic                      pick1;
  logic                      sel_rd;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [APP_DATA_WIDTH-1:0] sel_wdata;
  logic                      cmd_acc, data_acc;
  logic                      cmd_done_n, data_done_n;
  logic                      fifo_push, fifo_pop;
  logic                      fifo_head, fifo_full, fifo_empty;

  assign cmd_acc  = app_en_q & app_rdy;
  assign data_acc = wren_q & app_wdf_rdy;

  // A client whose ack is showing this cycle is still holding its old request,
  // so it must not be granted again on that stale request.
  assign elig0 = c0_req & ~ack_q[0] & ~(c0_rd & fifo_full);
  assign elig1 = c1_req & ~ack_q[1] & ~(c1_rd & fifo_full);

  // ---------------------------------------------------------------------------
  // Arbiter / issue FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_id_d    = gnt_id_q;
    app_en_d    = app_en_q;
    wren_d      = wren_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    ack_d       = 2'b00;
    fifo_push   = 1'b0;
    cmd_done_n  = cmd_done_q | cmd_acc;
    data_done_n = data_done_q | data_acc;
    // c1 wins when it is the only one eligible, or both are and c0 went last.
    pick1       = elig1 & (~elig0 | ~last_gnt_q);
    sel_rd      = pick1 ? c1_rd    : c0_rd;
    sel_addr    = pick1 ? c1_addr  : c0_addr;
    sel_wdata   = pick1 ? c1_wdata : c0_wdata;

    case (state_q)
      ST_IDLE: begin
        app_en_d = 1'b0;
        wren_d   = 1'b0;
        if (elig0 | elig1) begin
          gnt_id_d    = pick1;
          last_gnt_d  = pick1;
          app_en_d    = 1'b1;
          wren_d      = ~sel_rd;
          cmd_d       = sel_rd ? CMD_RD : CMD_WR;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          cmd_done_d  = 1'b0;
          // reads carry no write beat, so the data side is already finished
          data_done_d = sel_rd;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cmd_done_d  = cmd_done_n;
        data_done_d = data_done_n;
        if (cmd_acc)  app_en_d = 1'b0;
        if (data_acc) wren_d   = 1'b0;
        // record the owner of a read the moment MIG takes the command
        fifo_push = cmd_acc & cmd_q[0];
        if (cmd_done_n && data_done_n) begin
          ack_d   = gnt_id_q ? 2'b10 : 2'b01;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-return routing
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_valid_d = 2'b00;
    error_d    = error_q;
    fifo_pop   = 1'b0;
    if (app_rd_data_valid) begin
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        rd_valid_d = fifo_head ? 2'b10 : 2'b01;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      gnt_id_q    <= 1'b0;
      app_en_q    <= 1'b0;
      wren_q      <= 1'b0;
      cmd_q       <= CMD_WR;
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      ack_q       <= 2'b00;
      rd_valid_q  <= 2'b00;
      rd_data_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_id_q    <= gnt_id_d;
      app_en_q    <= app_en_d;
      wren_q      <= wren_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      ack_q       <= ack_d;
      rd_valid_q  <= rd_valid_d;
      error_q     <= error_d;
      if (app_rd_data_valid) rd_data_q <= app_rd_data;
    end
  end

  mig_app_arbiter_id_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (fifo_push),
    .push_id_i (gnt_id_q),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign app_en       = app_en_q;
  assign app_wdf_wren = wren_q;
  assign app_cmd      = cmd_q;
  assign app_addr     = addr_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_end  = 1'b1;
  assign c0_ack       = ack_q[0];
  assign c1_ack       = ack_q[1];
  assign c0_rd_valid  = rd_valid_q[0];
  assign c1_rd_valid  = rd_valid_q[1];
  assign rd_data      = rd_data_q;
  assign error        = error_q;

endmodule
